ofm_csum_out: RTL and testbench
===============================

# ofm_csum_out

Parametrised transmit-side checksum-insert output engine. It pops one control word per frame from the control FIFO and streams the frame's beats from the data FIFO into the TX FIFO. On the way it overwrites a 16-bit checksum field at any even byte offset, applies a selectable checksum finishing mode, and optionally discards the frame. It sits between the MM2S checksum/offload front end and the 10GE MAC TX FIFO in the `tx_clk` domain.

## Interface
Parameters:
- `C_DATA_WIDTH`, 64: beat data width in bits; legal values are 64, 128, 256. Derived: `NB = C_DATA_WIDTH/8` bytes per beat, `NL = C_DATA_WIDTH/16` lanes.
- `C_CNT_WIDTH`, 32: width of the frame statistics counters.

Ports (W = C_DATA_WIDTH + NB + 1):
- `tx_clk` in 1: single clock for all logic.
- `mm2s_reset` in 1: **asynchronous, active-high reset.**
- `ctrl_fifo_rdata` in 35: fields are {drop[34], mode[33:32], insert_ofs[31:16], sum[15:0]}. First-word-fall-through (FWFT).
- `ctrl_fifo_empty` in 1: control FIFO empty.
- `ctrl_fifo_rden` out 1: pop one control word.
- `data_fifo_rdata` in W: fields are {last[W-1], keep[W-2:C_DATA_WIDTH], data}. Byte 0 is at bits [7:0]. FWFT.
- `data_fifo_empty` in 1: data FIFO empty.
- `data_fifo_rden` out 1: pop one data beat.
- `tx_fifo_wdata` out W: output beat, same format as `data_fifo_rdata`.
- `tx_fifo_wren` out 1: write strobe to the TX FIFO.
- `tx_fifo_afull` in 1: TX FIFO almost full; it must have at least 2 free entries when it asserts.
- `csum_err` out 1: one-cycle pulse when a requested insertion was not performed.
- `tx_frame_cnt` out C_CNT_WIDTH: count of frames forwarded; wraps.
- `drop_frame_cnt` out C_CNT_WIDTH: count of frames dropped; wraps.
- `dbg_state` out 4: state encoding, zero-extended.

## Operation
- States:
  - IDLE (0) goes to SOF when `~ctrl_fifo_empty`.
  - SOF (1) latches `ctrl_fifo_rdata` into drop/mode/ofs/sum registers, clears `beat_cnt` and the `hit` flag, then goes unconditionally to DATA.
  - DATA (2) goes to EOF on the cycle a beat with `last`=1 is popped.
  - EOF (3) asserts `ctrl_fifo_rden` for exactly one cycle, then returns to IDLE. Codes 4-7 return to IDLE.
- Pop rule: `data_fifo_rden = (state==DATA) & ~data_fifo_empty & ~tx_fifo_afull`. Back-pressure is checked on every beat, not only at start of frame.
- `beat_cnt` is 16 bits and increments on each pop.
- Insert condition: `mode != 00`, `ofs[0] == 0`, and popped `beat_cnt == ofs >> log2(NB)`.
- Insert target: lane `(ofs % NB) / 2`, i.e. `data[16*l+15 : 16*l]`. The field never straddles beats.
- Inserted value by mode:
  - 00: no insert.
  - 01: `sum`.
  - 10: `~sum`.
  - 11: `sum`, except 16'h0000 is sent as 16'hFFFF (UDP rule).
- `hit` is set on insertion. Only one insertion occurs per frame.
- `csum_err` pulses in the EOF cycle when `mode != 00` and `hit == 0`. This covers an odd `ofs` and an `ofs` at or beyond the frame end.
- Drop frames (`drop` = 1):
  - All beats are popped normally, with no `afull` dependency: `rden = DATA & ~empty`.
  - `tx_fifo_wren` stays 0 for the whole frame.
  - `drop_frame_cnt` increments in EOF, and `csum_err` is suppressed.
- Non-drop frames: `tx_frame_cnt` increments in EOF.
- `keep` and `last` pass through unmodified. The byte count is not checked against `keep`.

## Timing
- Output pipeline: one registered stage. The beat popped in cycle N appears on `tx_fifo_wdata`/`tx_fifo_wren` in cycle N+1.
- Per-frame overhead is 3 idle cycles (IDLE, SOF, EOF). Peak throughput is 1 beat/cycle inside DATA.
- The ctrl word is held (not popped) until EOF, so `ctrl_fifo_rdata` remains valid as a debug view. All decisions use the latched copy.
- Data-FIFO empty mid-frame: the FSM stalls in DATA, produces no write, and holds `beat_cnt`.
- If `tx_fifo_afull` asserts in the same cycle as a pop, that pop is still not issued: `afull` gates the pop combinationally. The one already-registered beat is written the next cycle; this is why the 2-entry margin is required.
- Reset, asynchronous and active-high, including mid-frame:
  - State goes to IDLE.
  - `tx_fifo_wren`, `ctrl_fifo_rden`, `data_fifo_rden`, `csum_err` go to 0.
  - `tx_fifo_wdata`, `beat_cnt`, `hit`, and both counters go to 0.
  - A partial frame is abandoned; upstream FIFOs are flushed by the same reset.
- Counters update on the clock edge leaving EOF and are visible the following cycle.

## Test plan
- **64-bit, mode 01, ofs=40, sum=16'hBEEF, 8-beat frame:** beat 5 lane 0 reads BEEF. All other data is bit-exact. `tx_frame_cnt` = 1 and `csum_err` = 0.
- **128-bit, mode 11, ofs=22, sum=0, 4 beats:** beat 1 lane 3 reads FFFF. Repeat with mode 10 and sum=16'h1234: the lane reads EDCB.
- **Error cases:** ofs=41 (odd) gives no modification and one `csum_err` pulse in EOF. ofs=200 on a 3-beat 64-bit frame gives the same result.
- **Drop:** drop=1 on a 6-beat frame gives zero `tx_fifo_wren`, 6 data pops, 1 ctrl pop, and `drop_frame_cnt` = 1. The next normal frame is forwarded intact.
- **Back-pressure:** assert `afull` for 5 cycles mid-frame, and randomize `data_fifo_empty`. Output beats are in order with no loss or duplication, and no write occurs while `afull` has been high for 2 or more cycles.
- **Reset mid-frame:** assert `mm2s_reset` during beat 3. All outputs read 0 asynchronously. After release with fresh FIFOs, the next frame is correct and both counters restart from 0.

Source files
------------

// File: rtl/ofm_csum_out_if.sv
// FIFO-side bundle for ofm_csum_out: control and data FWFT read ports plus the TX FIFO write port.
interface ofm_csum_out_if #(
    parameter int C_DATA_WIDTH = 64
);
    localparam int W = C_DATA_WIDTH + C_DATA_WIDTH / 8 + 1;

    // Handshake: both read FIFOs are FWFT, so *_rdata is valid whenever *_empty is low and the
    // word is consumed in every cycle *_rden is high (rden never asserts while empty).
    // tx_fifo_wren is a write strobe with no ready; the writer throttles itself from tx_fifo_afull.
    logic [34:0]  ctrl_fifo_rdata;
    logic         ctrl_fifo_empty;
    logic         ctrl_fifo_rden;
    logic [W-1:0] data_fifo_rdata;
    logic         data_fifo_empty;
    logic         data_fifo_rden;
    logic [W-1:0] tx_fifo_wdata;
    logic         tx_fifo_wren;
    logic         tx_fifo_afull;

    modport master (
        input  ctrl_fifo_rdata, ctrl_fifo_empty, data_fifo_rdata, data_fifo_empty, tx_fifo_afull,
        output ctrl_fifo_rden, data_fifo_rden, tx_fifo_wdata, tx_fifo_wren
    );

    modport slave (
        output ctrl_fifo_rdata, ctrl_fifo_empty, data_fifo_rdata, data_fifo_empty, tx_fifo_afull,
        input  ctrl_fifo_rden, data_fifo_rden, tx_fifo_wdata, tx_fifo_wren
    );
endinterface

// File: rtl/ofm_csum_out.sv
// TX checksum-insert output engine: per-frame control word, 16-bit checksum field overwrite,
// optional frame drop, one registered stage into the TX FIFO.
module ofm_csum_out #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                   tx_clk,
    input  logic                   mm2s_reset,
    ofm_csum_out_if.master         fifo,
    output logic                   csum_err,
    output logic [C_CNT_WIDTH-1:0] tx_frame_cnt,
    output logic [C_CNT_WIDTH-1:0] drop_frame_cnt,
    output logic [3:0]             dbg_state
);
    localparam int NB  = C_DATA_WIDTH / 8;
    localparam int NL  = C_DATA_WIDTH / 16;
    localparam int LOG = $clog2(NB);
    localparam int W   = C_DATA_WIDTH + NB + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SOF  = 3'd1,
        S_DATA = 3'd2,
        S_EOF  = 3'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         drop_r;
    logic [1:0]   mode_r;
    logic [15:0]  ofs_r;
    logic [15:0]  sum_r;
    logic [15:0]  beat_cnt;
    logic         hit;
    logic         pop;
    logic         ins_now;
    logic [15:0]  fin_val;
    logic [LOG-2:0] lane;
    logic [W-1:0] beat_mod;

    // Drop frames drain regardless of TX back-pressure since nothing is written.
    assign pop  = (state == S_DATA) & ~fifo.data_fifo_empty & (drop_r | ~fifo.tx_fifo_afull);
    assign lane = ofs_r[LOG-1:1];
    assign ins_now = pop & ~hit & (mode_r != 2'b00) & ~ofs_r[0] &
                     (beat_cnt == (ofs_r >> LOG));

    always_comb begin
        fin_val = sum_r;
        case (mode_r)
            2'b10:   fin_val = ~sum_r;
            2'b11:   fin_val = (sum_r == 16'h0000) ? 16'hFFFF : sum_r;
            default: fin_val = sum_r;
        endcase
    end

    always_comb begin
        beat_mod = fifo.data_fifo_rdata;
        if (ins_now) begin
            for (int l = 0; l < NL; l++) begin
                if (int'(lane) == l) beat_mod[16*l +: 16] = fin_val;
            end
        end
    end

    // State register
    always_ff @(posedge tx_clk or posedge mm2s_reset) begin
        if (mm2s_reset) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = fifo.ctrl_fifo_empty ? S_IDLE : S_SOF;
            S_SOF:   state_nxt = S_DATA;
            S_DATA:  state_nxt = (pop && fifo.data_fifo_rdata[W-1]) ? S_EOF : S_DATA;
            S_EOF:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        fifo.ctrl_fifo_rden = (state == S_EOF);
        fifo.data_fifo_rden = pop;
        csum_err            = (state == S_EOF) & ~drop_r & (mode_r != 2'b00) & ~hit;
        dbg_state           = {1'b0, state};
    end

    // The ctrl word stays at the FIFO head until EOF; all decisions use this latched copy.
    always_ff @(posedge tx_clk or posedge mm2s_reset) begin
        if (mm2s_reset) begin
            drop_r   <= 1'b0;
            mode_r   <= 2'b00;
            ofs_r    <= 16'h0000;
            sum_r    <= 16'h0000;
            beat_cnt <= 16'h0000;
            hit      <= 1'b0;
        end else if (state == S_SOF) begin
            drop_r   <= fifo.ctrl_fifo_rdata[34];
            mode_r   <= fifo.ctrl_fifo_rdata[33:32];
            ofs_r    <= fifo.ctrl_fifo_rdata[31:16];
            sum_r    <= fifo.ctrl_fifo_rdata[15:0];
            beat_cnt <= 16'h0000;
            hit      <= 1'b0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (ins_now) hit <= 1'b1;
        end
    end

    always_ff @(posedge tx_clk or posedge mm2s_reset) begin
        if (mm2s_reset) begin
            fifo.tx_fifo_wdata <= '0;
            fifo.tx_fifo_wren  <= 1'b0;
        end else begin
            fifo.tx_fifo_wren <= pop & ~drop_r;
            if (pop) fifo.tx_fifo_wdata <= beat_mod;
        end
    end

    always_ff @(posedge tx_clk or posedge mm2s_reset) begin
        if (mm2s_reset) begin
            tx_frame_cnt   <= '0;
            drop_frame_cnt <= '0;
        end else if (state == S_EOF) begin
            if (drop_r) drop_frame_cnt <= drop_frame_cnt + 1'b1;
            else        tx_frame_cnt   <= tx_frame_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ofm_csum_out.sv
// Bench for ofm_csum_out: 64-bit and 128-bit instances fed from array-backed FWFT FIFO models.
module tb_ofm_csum_out;
    localparam int W64  = 73;
    localparam int W128 = 145;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    ofm_csum_out_if #(.C_DATA_WIDTH(64))  if64 ();
    ofm_csum_out_if #(.C_DATA_WIDTH(128)) if128 ();

    logic        err64, err128;
    logic [31:0] txc64, dropc64, txc128, dropc128;
    logic [3:0]  st64, st128;

    ofm_csum_out #(.C_DATA_WIDTH(64), .C_CNT_WIDTH(32)) u64 (
        .tx_clk(clk), .mm2s_reset(rst), .fifo(if64), .csum_err(err64),
        .tx_frame_cnt(txc64), .drop_frame_cnt(dropc64), .dbg_state(st64)
    );

    ofm_csum_out #(.C_DATA_WIDTH(128), .C_CNT_WIDTH(32)) u128 (
        .tx_clk(clk), .mm2s_reset(rst), .fifo(if128), .csum_err(err128),
        .tx_frame_cnt(txc128), .drop_frame_cnt(dropc128), .dbg_state(st128)
    );

    // ---------------- upstream FIFO models (FWFT, flushed by reset) ----------------
    logic [W64-1:0]  dm64  [0:255];
    logic [W128-1:0] dm128 [0:255];
    logic [34:0]     cm64  [0:15];
    logic [34:0]     cm128 [0:15];
    logic [7:0] d_wp64 = 8'd0, d_rp64 = 8'd0, d_wp128 = 8'd0, d_rp128 = 8'd0;
    logic [3:0] c_wp64 = 4'd0, c_rp64 = 4'd0, c_wp128 = 4'd0, c_rp128 = 4'd0;
    logic stall64 = 1'b0;
    logic afull64 = 1'b0;
    int dpop64 = 0, cpop64 = 0;

    assign if64.data_fifo_rdata  = dm64[d_rp64];
    assign if64.data_fifo_empty  = (d_rp64 == d_wp64) | stall64;
    assign if64.ctrl_fifo_rdata  = cm64[c_rp64];
    assign if64.ctrl_fifo_empty  = (c_rp64 == c_wp64);
    assign if64.tx_fifo_afull    = afull64;
    assign if128.data_fifo_rdata = dm128[d_rp128];
    assign if128.data_fifo_empty = (d_rp128 == d_wp128);
    assign if128.ctrl_fifo_rdata = cm128[c_rp128];
    assign if128.ctrl_fifo_empty = (c_rp128 == c_wp128);
    assign if128.tx_fifo_afull   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rp64  <= d_wp64;
            c_rp64  <= c_wp64;
            d_rp128 <= d_wp128;
            c_rp128 <= c_wp128;
        end else begin
            if (if64.data_fifo_rden)  begin d_rp64 <= d_rp64 + 8'd1; dpop64 <= dpop64 + 1; end
            if (if64.ctrl_fifo_rden)  begin c_rp64 <= c_rp64 + 4'd1; cpop64 <= cpop64 + 1; end
            if (if128.data_fifo_rden) d_rp128 <= d_rp128 + 8'd1;
            if (if128.ctrl_fifo_rden) c_rp128 <= c_rp128 + 4'd1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [W64-1:0]  exp64_q[$];
    logic [W128-1:0] exp128_q[$];
    int exp_tx64 = 0, exp_drop64 = 0, exp_tx128 = 0;
    int wrs64 = 0, errs64 = 0, errs128 = 0;
    logic afull_prev64 = 1'b0;
    logic [W64-1:0]  got64;
    logic [W128-1:0] got128;

    always @(negedge clk) begin
        if (!rst) begin
            if (err64) errs64++;
            if (if64.tx_fifo_wren) begin
                wrs64++;
                tests++;
                if (afull_prev64 && afull64) begin
                    fails++;
                    $display("FAIL afull_write64: wren=1 required 0 after 2+ cycles of afull");
                end
                tests++;
                if (exp64_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat64: got %h, required no write", if64.tx_fifo_wdata);
                end else begin
                    got64 = exp64_q.pop_front();
                    if (if64.tx_fifo_wdata !== got64) begin
                        fails++;
                        $display("FAIL beat64: got %h required %h", if64.tx_fifo_wdata, got64);
                    end
                end
            end
            afull_prev64 = afull64;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (err128) errs128++;
            if (if128.tx_fifo_wren) begin
                tests++;
                if (exp128_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat128: got %h, required no write", if128.tx_fifo_wdata);
                end else begin
                    got128 = exp128_q.pop_front();
                    if (if128.tx_fifo_wdata !== got128) begin
                        fails++;
                        $display("FAIL beat128: got %h required %h", if128.tx_fifo_wdata, got128);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [W128-1:0] act, input logic [W128-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Loads a whole frame into the data FIFO, then its control word; exp_val is the lane value
    // the frame must carry when exp_ins is set.
    task automatic send_frame(input bit wide, input bit drop, input logic [1:0] mode,
                              input logic [15:0] ofs, input logic [15:0] sum, input int beats,
                              input bit exp_ins, input logic [15:0] exp_val, input int seed);
        int nbytes;
        int a;
        logic [127:0] d;
        logic [127:0] e;
        logic [7:0]   v;
        logic         last;
        nbytes = wide ? 16 : 8;
        for (int i = 0; i < beats; i++) begin
            d = '0;
            e = '0;
            for (int b = 0; b < nbytes; b++) begin
                a = i * nbytes + b;
                v = 8'((a * 37 + seed) & 255);
                d[8*b +: 8] = v;
                e[8*b +: 8] = v;
                if (exp_ins && a == int'(ofs))     e[8*b +: 8] = exp_val[7:0];
                if (exp_ins && a == int'(ofs) + 1) e[8*b +: 8] = exp_val[15:8];
            end
            last = (i == beats - 1);
            if (wide) begin
                dm128[d_wp128] = {last, (last ? 16'h0FFF : 16'hFFFF), d};
                d_wp128 = d_wp128 + 8'd1;
                if (!drop) exp128_q.push_back({last, (last ? 16'h0FFF : 16'hFFFF), e});
            end else begin
                dm64[d_wp64] = {last, (last ? 8'h3F : 8'hFF), d[63:0]};
                d_wp64 = d_wp64 + 8'd1;
                if (!drop) exp64_q.push_back({last, (last ? 8'h3F : 8'hFF), e[63:0]});
            end
        end
        if (wide) begin
            cm128[c_wp128] = {drop, mode, ofs, sum};
            c_wp128 = c_wp128 + 4'd1;
            if (!drop) exp_tx128++;
        end else begin
            cm64[c_wp64] = {drop, mode, ofs, sum};
            c_wp64 = c_wp64 + 4'd1;
            if (drop) exp_drop64++;
            else      exp_tx64++;
        end
    endtask

    task automatic wait_idle(input bit wide);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (wide) done = (exp128_q.size() == 0) && (c_rp128 == c_wp128) && (st128 == 4'd0);
            else      done = (exp64_q.size() == 0) && (c_rp64 == c_wp64) && (st64 == 4'd0);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL wait_idle%0d: frame not finished after %0d cycles, required done", wide ? 128 : 64, n);
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    int s_err, s_wr, s_dpop, s_cpop, n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_wren64",  if64.tx_fifo_wren,  0);
        check("rst_wdata64", if64.tx_fifo_wdata, 0);
        check("rst_state64", st64, 0);
        check("rst_txcnt64", txc64, 0);
        check("rst_err64",   err64, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 64-bit mode 01, ofs 40: beat 5 lane 0 = BEEF
        s_err = errs64;
        send_frame(0, 0, 2'b01, 16'd40, 16'hBEEF, 8, 1, 16'hBEEF, 1);
        wait_idle(0);
        check("m01_txcnt", txc64, 1);
        check("m01_err",   errs64 - s_err, 0);

        // odd offset: untouched, one error pulse
        s_err = errs64;
        send_frame(0, 0, 2'b01, 16'd41, 16'hBEEF, 8, 0, 16'h0000, 2);
        wait_idle(0);
        check("odd_err", errs64 - s_err, 1);

        // offset past frame end
        s_err = errs64;
        send_frame(0, 0, 2'b01, 16'd200, 16'hBEEF, 3, 0, 16'h0000, 3);
        wait_idle(0);
        check("past_err",   errs64 - s_err, 1);
        check("past_txcnt", txc64, 3);

        // drop frame with afull held high: still drains, no writes, error suppressed
        s_err = errs64; s_wr = wrs64; s_dpop = dpop64; s_cpop = cpop64;
        afull64 = 1'b1;
        send_frame(0, 1, 2'b01, 16'd41, 16'h1234, 6, 0, 16'h0000, 4);
        wait_idle(0);
        afull64 = 1'b0;
        check("drop_wr",    wrs64 - s_wr, 0);
        check("drop_dpop",  dpop64 - s_dpop, 6);
        check("drop_cpop",  cpop64 - s_cpop, 1);
        check("drop_err",   errs64 - s_err, 0);
        check("drop_cnt",   dropc64, exp_drop64);
        check("drop_txcnt", txc64, exp_tx64);

        // mode 00 after drop: forwarded intact
        s_err = errs64;
        send_frame(0, 0, 2'b00, 16'd0, 16'hFFFF, 4, 0, 16'h0000, 5);
        wait_idle(0);
        check("m00_err",   errs64 - s_err, 0);
        check("m00_txcnt", txc64, exp_tx64);

        // back-pressure with a random empty pattern
        @(negedge clk);
        fork
            send_frame(0, 0, 2'b01, 16'd16, 16'h5A5A, 12, 1, 16'h5A5A, 6);
            begin
                repeat (30) begin @(posedge clk); #2 stall64 = ($urandom_range(0, 2) == 0); end
                @(posedge clk); #2 stall64 = 1'b0;
            end
            begin
                repeat (6) @(posedge clk); #2 afull64 = 1'b1;
                repeat (5) @(posedge clk); #2 afull64 = 1'b0;
            end
        join
        wait_idle(0);
        check("bp_txcnt", txc64, exp_tx64);

        // 128-bit: mode 11 zero sum -> FFFF, mode 10 1234 -> EDCB, both at beat 1 lane 3
        s_err = errs128;
        send_frame(1, 0, 2'b11, 16'd22, 16'h0000, 4, 1, 16'hFFFF, 7);
        wait_idle(1);
        send_frame(1, 0, 2'b10, 16'd22, 16'h1234, 4, 1, 16'hEDCB, 8);
        wait_idle(1);
        check("w128_txcnt", txc128, exp_tx128);
        check("w128_drop",  dropc128, 0);
        check("w128_err",   errs128 - s_err, 0);

        // reset in the middle of a frame
        s_dpop = dpop64;
        send_frame(0, 0, 2'b01, 16'd2, 16'h1111, 8, 1, 16'h1111, 9);
        n = 0;
        while (dpop64 - s_dpop < 3 && n < 200) begin @(negedge clk); n++; end
        check("rst_reach_beat3", (dpop64 - s_dpop >= 3) ? 1 : 0, 1);
        #1 rst = 1'b1;
        #1;
        check("mrst_wren",   if64.tx_fifo_wren,   0);
        check("mrst_wdata",  if64.tx_fifo_wdata,  0);
        check("mrst_drden",  if64.data_fifo_rden, 0);
        check("mrst_crden",  if64.ctrl_fifo_rden, 0);
        check("mrst_err",    err64,   0);
        check("mrst_state",  st64,    0);
        check("mrst_txcnt",  txc64,   0);
        check("mrst_drop",   dropc64, 0);
        check("mrst_tx128",  txc128,  0);
        repeat (3) @(negedge clk);
        exp64_q.delete();
        exp_tx64 = 0;
        exp_drop64 = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        s_err = errs64;
        send_frame(0, 0, 2'b11, 16'd6, 16'h0000, 3, 1, 16'hFFFF, 10);
        wait_idle(0);
        check("post_txcnt", txc64, 1);
        check("post_drop",  dropc64, 0);
        check("post_err",   errs64 - s_err, 0);

        check("drain64",  exp64_q.size(),  0);
        check("drain128", exp128_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
